// File: rtl/input_debounce_if.sv
// Pin-conditioning bus between the raw pin source and the debounce block.
// The pin source drives a; the debouncer returns the clean level, edge pulses and counters.
`timescale 1ns/1ps
interface input_debounce_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 a;
    logic                 b;
    logic                 rise;
    logic                 fall;
    logic [CNT_WIDTH-1:0] count;
    logic [7:0]           glitches;

    modport master (
        output a,
        input  b,
        input  rise,
        input  fall,
        input  count,
        input  glitches
    );

    modport slave (
        input  a,
        output b,
        output rise,
        output fall,
        output count,
        output glitches
    );
endinterface

// File: rtl/input_debounce.sv
// Synchronises and debounces a raw pin: clean level, single-cycle rise/fall pulses,
// a wrapping rise counter and a saturating count of aborted transitions.
`timescale 1ns/1ps
module input_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input_debounce_if.slave   bus
);

    localparam int PCNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_RISE_PEND = 2'd1,
        ST_HIGH      = 2'd2,
        ST_FALL_PEND = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sy;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [PCNT_W-1:0]      r_pcnt;
    logic [PCNT_W-1:0]      w_pcnt_next;

    logic                   r_b;
    logic                   r_rise;
    logic                   r_fall;
    logic [CNT_WIDTH-1:0]   r_count;
    logic [7:0]             r_glitches;

    logic                   w_accept;
    logic                   w_abort;
    logic                   w_b_next;
    logic                   w_rise_next;
    logic                   w_fall_next;
    logic [CNT_WIDTH-1:0]   w_count_next;
    logic [7:0]             w_glitches_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.a};
        end
    end

    assign w_sy = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_LOW;
            r_pcnt     <= '0;
            r_b        <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_count    <= '0;
            r_glitches <= 8'd0;
        end else begin
            r_state    <= w_state_next;
            r_pcnt     <= w_pcnt_next;
            r_b        <= w_b_next;
            r_rise     <= w_rise_next;
            r_fall     <= w_fall_next;
            r_count    <= w_count_next;
            r_glitches <= w_glitches_next;
        end
    end

    // r_pcnt counts mismatching samples already seen; the one arriving now makes it r_pcnt+1.
    always_comb begin
        w_state_next = r_state;
        w_pcnt_next  = r_pcnt;
        w_accept     = 1'b0;
        w_abort      = 1'b0;

        case (r_state)
            ST_LOW, ST_HIGH: begin
                if (w_sy == r_b) begin
                    w_pcnt_next = '0;
                end else if (DEBOUNCE_CYCLES == 1) begin
                    w_accept = 1'b1;
                end else begin
                    w_pcnt_next  = PCNT_ONE;
                    w_state_next = (r_state == ST_LOW) ? ST_RISE_PEND : ST_FALL_PEND;
                end
            end
            ST_RISE_PEND, ST_FALL_PEND: begin
                if (w_sy == r_b) begin
                    w_abort      = 1'b1;
                    w_pcnt_next  = '0;
                    w_state_next = r_b ? ST_HIGH : ST_LOW;
                end else if (r_pcnt == PCNT_LAST) begin
                    w_accept = 1'b1;
                end else begin
                    w_pcnt_next = r_pcnt + PCNT_ONE;
                end
            end
            default: begin
                w_state_next = ST_LOW;
                w_pcnt_next  = '0;
            end
        endcase

        if (w_accept) begin
            w_state_next = r_b ? ST_LOW : ST_HIGH;
            w_pcnt_next  = '0;
        end
    end

    always_comb begin
        w_b_next        = r_b ^ w_accept;
        w_rise_next     = w_accept & ~r_b;
        w_fall_next     = w_accept & r_b;
        w_count_next    = r_count;
        w_glitches_next = r_glitches;

        if (w_accept && !r_b) begin
            w_count_next = r_count + CNT_WIDTH'(1);
        end
        if (w_abort && (r_glitches != 8'hFF)) begin
            w_glitches_next = r_glitches + 8'd1;
        end
    end

    assign bus.b        = r_b;
    assign bus.rise     = r_rise;
    assign bus.fall     = r_fall;
    assign bus.count    = r_count;
    assign bus.glitches = r_glitches;

endmodule

// File: tb/tb_input_debounce.sv
// Bench for input_debounce: directed scenarios plus random pin activity, every cycle
// compared against a sample-run reference model of the debouncing rules.
`timescale 1ns/1ps
module tb_input_debounce;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int CW   = 4;

    logic clk;
    logic rst;

    input_debounce_if #(.CNT_WIDTH(CW)) ifc ();

    input_debounce #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_WIDTH       (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #41.667 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: pin samples delayed SYNC edges, then a run of mismatching samples.
    logic m_sy_q[$];
    logic m_b;
    logic m_rise;
    logic m_fall;
    int   m_run;
    int   m_count;
    int   m_glitch;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sy_q.delete();
        for (int i = 0; i < SYNC; i++) m_sy_q.push_back(1'b0);
        m_b      = 1'b0;
        m_rise   = 1'b0;
        m_fall   = 1'b0;
        m_run    = 0;
        m_count  = 0;
        m_glitch = 0;
    endtask

    task automatic model_edge(input logic a_now);
        logic sy;
        sy = m_sy_q.pop_front();
        m_sy_q.push_back(a_now);
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (sy != m_b) begin
            m_run++;
            if (m_run == DEB) begin
                m_b = ~m_b;
                if (m_b) begin
                    m_rise  = 1'b1;
                    m_count = (m_count + 1) % (1 << CW);
                end else begin
                    m_fall = 1'b1;
                end
                m_run = 0;
            end
        end else if (m_run > 0) begin
            if (m_glitch < 255) m_glitch++;
            m_run = 0;
        end
    endtask

    // Called just after a falling edge: drive, take one rising edge, compare at the next falling edge.
    task automatic tick(input logic a_val, input logic rst_val);
        ifc.a = a_val;
        rst   = rst_val;
        if (rst_val) model_reset();
        @(posedge clk);
        if (rst_val) model_reset();
        else         model_edge(a_val);
        @(negedge clk);
        check("b",        32'(ifc.b),        32'(m_b));
        check("rise",     32'(ifc.rise),     32'(m_rise));
        check("fall",     32'(ifc.fall),     32'(m_fall));
        check("count",    32'(ifc.count),    32'(m_count));
        check("glitches", 32'(ifc.glitches), 32'(m_glitch));
        check("rise_and_fall", 32'(ifc.rise & ifc.fall), 32'(0));
    endtask

    initial begin
        int run_left;
        logic a_rand;
        logic r_rand;

        ifc.a = 1'b0;
        rst   = 1'b1;
        model_reset();
        @(negedge clk);

        // Reset held while the pin toggles every cycle.
        for (int i = 0; i < 10; i++) begin
            tick(i[0], 1'b1);
            check("t1_b",        32'(ifc.b),        32'(0));
            check("t1_count",    32'(ifc.count),    32'(0));
            check("t1_glitches", 32'(ifc.glitches), 32'(0));
        end
        $display("t1 reset-hold: b=%0d count=%0d glitches=%0d", ifc.b, ifc.count, ifc.glitches);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);

        // Clean rise: accepted at the 6th edge, one-cycle pulse.
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, 1'b0);
            check("t2_b",    32'(ifc.b),    32'(i >= 6));
            check("t2_rise", 32'(ifc.rise), 32'(i == 6));
        end
        check("t2_count", 32'(ifc.count), 32'(1));
        check("t2_glitches", 32'(ifc.glitches), 32'(0));
        $display("t2 clean rise: b=%0d count=%0d", ifc.b, ifc.count);

        // Clean fall: count unchanged.
        for (int i = 1; i <= 8; i++) begin
            tick(1'b0, 1'b0);
            check("t4_b",    32'(ifc.b),    32'(i < 6));
            check("t4_fall", 32'(ifc.fall), 32'(i == 6));
        end
        check("t4_count", 32'(ifc.count), 32'(1));
        $display("t4 clean fall: b=%0d count=%0d", ifc.b, ifc.count);

        // 3-cycle glitches, saturating at 255.
        for (int n = 1; n <= 300; n++) begin
            for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
            for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);
            check("t3_glitches", 32'(ifc.glitches), 32'((n < 255) ? n : 255));
            check("t3_b", 32'(ifc.b), 32'(0));
        end
        check("t3_count", 32'(ifc.count), 32'(1));
        $display("t3 glitches: glitches=%0d b=%0d", ifc.glitches, ifc.b);

        // Counter wrap from a fresh reset.
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        for (int r = 1; r <= 16; r++) begin
            for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
            check("t5_count", 32'(ifc.count), 32'(r % 16));
            for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);
        end
        check("t5_glitches", 32'(ifc.glitches), 32'(0));
        $display("t5 wrap: count=%0d", ifc.count);

        // Reset in the middle of a pending rise, released with the pin still high.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, 1'b0);
            check("t6_b", 32'(ifc.b), 32'(i >= 6));
        end
        check("t6_count",    32'(ifc.count),    32'(1));
        check("t6_glitches", 32'(ifc.glitches), 32'(0));
        $display("t6 reset mid-pending: b=%0d count=%0d glitches=%0d", ifc.b, ifc.count, ifc.glitches);

        // Random pin activity with occasional resets.
        run_left = 0;
        a_rand   = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (run_left == 0) begin
                a_rand   = 1'($urandom_range(0, 1));
                run_left = $urandom_range(1, 7);
            end
            run_left--;
            r_rand = ($urandom_range(0, 79) == 0);
            tick(a_rand, r_rand);
        end
        $display("random: b=%0d count=%0d glitches=%0d", ifc.b, ifc.count, ifc.glitches);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
